// File: rtl/reg_timeout_cut_pkg.sv
// Shared register-bus types and sizing helpers for the reg_timeout_cut slice.
// The default request/response structs match the 32-bit register interface.
package reg_timeout_cut_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              valid;
    } reg_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_timeout_cut_counter.sv
// Free-running up counter with synchronous clear, used as the watchdog timer.
module reg_timeout_cut_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/reg_timeout_cut.sv
// Register-bus pipeline cut with a bounded-response watchdog: registers the request,
// answers the master with an error if the subordinate stalls, then absorbs the late ack.
module reg_timeout_cut
    import reg_timeout_cut_pkg::*;
#(
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t,
    parameter int unsigned TimeoutCycles = 32,
    parameter bit          Bypass        = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t src_req_i,
    output rsp_t src_rsp_o,
    output req_t dst_req_o,
    input  rsp_t dst_rsp_i,
    output logic busy_o,
    output logic timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_ERR_RESP,
        ST_DRAIN
    } state_e;

    if (Bypass) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk_i, rst_ni};

        assign dst_req_o = src_req_i;
        assign src_rsp_o = dst_rsp_i;
        assign busy_o    = 1'b0;
        assign timeout_o = 1'b0;
    end else begin : g_cut
        localparam int unsigned CNT_W = cnt_width(TimeoutCycles);
        localparam logic [CNT_W-1:0] LIMIT =
            CNT_W'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

        state_e           state, state_next;
        req_t             req_q;
        rsp_t             rsp_q;
        logic [CNT_W-1:0] cnt;
        logic             capture_req, capture_rsp, cnt_clr, cnt_en, at_limit;

        reg_timeout_cut_counter #(
            .WIDTH (CNT_W)
        ) u_cnt (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .clear (cnt_clr),
            .en    (cnt_en),
            .count (cnt)
        );

        // A zero timeout means wait forever; the counter then simply wraps unobserved.
        assign at_limit = (TimeoutCycles != 0) && (cnt == LIMIT);

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state <= ST_IDLE;
                req_q <= '0;
                rsp_q <= '0;
            end else begin
                state <= state_next;
                if (capture_req) req_q <= src_req_i;
                if (capture_rsp) rsp_q <= dst_rsp_i;
            end
        end

        always_comb begin
            state_next      = state;
            capture_req     = 1'b0;
            capture_rsp     = 1'b0;
            cnt_clr         = 1'b0;
            cnt_en          = 1'b0;
            timeout_o       = 1'b0;
            dst_req_o       = req_q;
            dst_req_o.valid = 1'b0;
            src_rsp_o       = '0;

            unique case (state)
                ST_IDLE: begin
                    if (src_req_i.valid) begin
                        capture_req = 1'b1;
                        cnt_clr     = 1'b1;
                        state_next  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    dst_req_o.valid = 1'b1;
                    // A ready coinciding with the limit still counts as a normal completion.
                    if (dst_rsp_i.ready) begin
                        capture_rsp = 1'b1;
                        state_next  = ST_RESP;
                    end else if (at_limit) begin
                        timeout_o  = 1'b1;
                        state_next = ST_ERR_RESP;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_RESP: begin
                    src_rsp_o       = rsp_q;
                    src_rsp_o.ready = 1'b1;
                    state_next      = ST_IDLE;
                end
                ST_ERR_RESP: begin
                    // valid may not be retracted on the subordinate side, so keep asking.
                    dst_req_o.valid = 1'b1;
                    src_rsp_o.error = 1'b1;
                    src_rsp_o.ready = 1'b1;
                    state_next      = dst_rsp_i.ready ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    dst_req_o.valid = 1'b1;
                    if (dst_rsp_i.ready) state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        assign busy_o = (state != ST_IDLE);
    end

endmodule
